// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between producers, with bounded bursts.
// Optional macro FIFO_ARB_LOCK_EN adds req_lock_i, letting the owner extend its burst.
module fifo_wr_arbiter #(
    parameter int data_word_size_g = 8,
    parameter int num_requesters_g = 4,
    parameter int max_burst_g      = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         clk_en_i,
    input  logic [num_requesters_g-1:0]                  req_valid_i,
    input  logic [num_requesters_g*data_word_size_g-1:0] req_data_i,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [num_requesters_g-1:0]                  req_lock_i,
`endif
    output logic [num_requesters_g-1:0]                  req_ready_o,
    output logic [num_requesters_g-1:0]                  grant_o,
    output logic                                         w_en_o,
    output logic [data_word_size_g-1:0]                  w_data_o,
    input  logic                                         w_full_i
);

    localparam int N  = num_requesters_g;
    localparam int W  = data_word_size_g;
    localparam int IW = $clog2(num_requesters_g);
    localparam int CW = $clog2(max_burst_g + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IW:0]     win_idle, win_rel;
    logic [IW-1:0]   nxt_ptr;
    logic            in_grant, owner_vld, accept, locked, at_max, last_beat, release_now;

    // Returns {found, index} of the first valid bit at or above ptr, wrapping.
    function automatic logic [IW:0] arbitrate(input logic [N-1:0] vld, input logic [IW-1:0] ptr);
        logic [IW:0]   res;
        logic [IW-1:0] kk;
        int            k;
        res = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!res[IW] && vld[kk]) res = {1'b1, kk};
        end
        return res;
    endfunction

`ifdef FIFO_ARB_LOCK_EN
    assign locked = req_lock_i[owner_q];
`else
    assign locked = 1'b0;
`endif

    assign in_grant    = (state_q == GRANT);
    assign owner_vld   = req_valid_i[owner_q];
    assign accept      = in_grant & owner_vld & ~w_full_i & clk_en_i;
    assign at_max      = (beat_cnt_q == CW'(max_burst_g));
    assign last_beat   = accept & (beat_cnt_q == CW'(max_burst_g - 1));
    // A locked owner keeps the port; once the lock drops a saturated count releases at once.
    assign release_now = ~owner_vld | (~locked & (last_beat | at_max));
    assign nxt_ptr     = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign win_idle    = arbitrate(req_valid_i, rr_ptr_q);
    assign win_rel     = arbitrate(req_valid_i, nxt_ptr);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_idle[IW]) begin
                    state_d    = GRANT;
                    owner_d    = win_idle[IW-1:0];
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_d   = nxt_ptr;
                    beat_cnt_d = '0;
                    if (win_rel[IW]) owner_d = win_rel[IW-1:0];
                    else             state_d = IDLE;
                end else if (accept && !at_max) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (clk_en_i) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_o     = in_grant ? (N'(1) << owner_q) : '0;
    assign w_en_o      = accept;
    assign w_data_o    = in_grant ? req_data_i[int'(owner_q)*W +: W] : '0;
    assign req_ready_o = grant_o & {N{~w_full_i & clk_en_i}};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers against a reference model.
module tb_fifo_wr_arbiter;
    localparam int N = 4, W = 8, B = 4;

    logic           clk = 1'b0;
    logic           rst, clk_en, w_full, w_en;
    logic [N-1:0]   valid, ready, grant;
    logic [N*W-1:0] data;
    logic [W-1:0]   w_data;
`ifdef FIFO_ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.data_word_size_g(W), .num_requesters_g(N), .max_burst_g(B)) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
        .req_valid_i(valid), .req_data_i(data),
`ifdef FIFO_ARB_LOCK_EN
        .req_lock_i(lock),
`endif
        .req_ready_o(ready), .grant_o(grant),
        .w_en_o(w_en), .w_data_o(w_data), .w_full_i(w_full)
    );

    // Reference model: who owns the port, where the search starts, beats taken so far.
    int m_busy, m_owner, m_ptr, m_cnt;
    logic [N-1:0] e_grant, e_ready;
    logic         e_wen;
    logic [W-1:0] e_wdata;

    function automatic int winner(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic model_reset;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic calc_exp;
        e_grant = '0;
        if (m_busy != 0) e_grant[m_owner] = 1'b1;
        e_wen   = (m_busy != 0) && valid[m_owner] && !w_full && clk_en;
        e_wdata = (m_busy != 0) ? data[m_owner*W +: W] : '0;
        e_ready = (!w_full && clk_en) ? e_grant : '0;
    endtask

    task automatic model_step;
        int w, cnt, locked, rel;
        if (!clk_en) return;
        if (m_busy == 0) begin
            w = winner(valid, m_ptr);
            if (w >= 0) begin m_busy = 1; m_owner = w; m_cnt = 0; end
        end else begin
            locked = 0;
`ifdef FIFO_ARB_LOCK_EN
            locked = lock[m_owner];
`endif
            cnt = m_cnt + ((valid[m_owner] && !w_full) ? 1 : 0);
            rel = 0;
            if (!valid[m_owner]) rel = 1;
            else if (locked != 0) cnt = (cnt > B) ? B : cnt;
            else if (cnt >= B) rel = 1;
            if (rel != 0) begin
                m_ptr = (m_owner + 1) % N;
                w = winner(valid, m_ptr);
                m_cnt = 0;
                if (w >= 0) m_owner = w; else m_busy = 0;
            end else m_cnt = cnt;
        end
    endtask

    task automatic cycle;
        model_step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        model_reset;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        valid = '1;
        data  = {$urandom, $urandom} | 32'h0101_0101;
        #1;
        total++; if (grant !== '0)  begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (w_en !== 1'b0) begin bad++; $display("FAIL reset_w_en: got %b want 0", w_en); end
        total++; if (ready !== '0)  begin bad++; $display("FAIL reset_ready: got %b want 0000", ready); end
        total++; if (w_data !== '0) begin bad++; $display("FAIL reset_w_data: got %h want 00", w_data); end
        valid = '0;
        rst   = 1'b0;
    endtask

    task automatic test_single;
        valid = 4'b0100;
        data[2*W +: W] = 8'hA0;
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_idle: got %b want 0000", grant); end
        cycle;
        for (int i = 0; i < 3; i++) begin
            data[2*W +: W] = 8'hA0 + 8'(i);
            #1;
            total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant[%0d]: got %b want 0100", i, grant); end
            total++; if (w_en !== 1'b1) begin bad++; $display("FAIL single_w_en[%0d]: got %b want 1", i, w_en); end
            total++; if (w_data !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL single_data[%0d]: got %h want %h", i, w_data, 8'hA0 + 8'(i)); end
            cycle;
        end
        valid = '0;
        #1;
        total++; if (w_en !== 1'b0) begin bad++; $display("FAIL single_drop_w_en: got %b want 0", w_en); end
        cycle;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release: got %b want 0000", grant); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] eg;
        int exp_o;
        do_reset;
        data  = {$urandom, $urandom};
        valid = 4'b1111;
        cycle;
        for (int c = 0; c < 20; c++) begin
            exp_o = (c / 4) % 4;
            eg = '0; eg[exp_o] = 1'b1;
            #1;
            total++; if (grant !== eg) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", c, grant, eg); end
            total++; if (w_en !== 1'b1) begin bad++; $display("FAIL rr_w_en[%0d]: got %b want 1", c, w_en); end
            total++; if (w_data !== data[exp_o*W +: W]) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", c, w_data, data[exp_o*W +: W]); end
            cycle;
        end
        valid = '0;
        cycle;
    endtask

    task automatic test_full_stall;
        do_reset;
        valid = 4'b0001;
        cycle;
        for (int i = 0; i < 2; i++) begin
            #1; total++; if (w_en !== 1'b1) begin bad++; $display("FAIL full_pre_w_en[%0d]: got %b want 1", i, w_en); end
            cycle;
        end
        w_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (w_en !== 1'b0) begin bad++; $display("FAIL full_w_en[%0d]: got %b want 0", i, w_en); end
            total++; if (ready !== 4'b0000) begin bad++; $display("FAIL full_ready[%0d]: got %b want 0000", i, ready); end
            total++; if (grant !== 4'b0001) begin bad++; $display("FAIL full_grant[%0d]: got %b want 0001", i, grant); end
            cycle;
        end
        w_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (w_en !== 1'b1) begin bad++; $display("FAIL full_post_w_en[%0d]: got %b want 1", i, w_en); end
            total++; if (ready !== 4'b0001) begin bad++; $display("FAIL full_post_ready[%0d]: got %b want 0001", i, ready); end
            cycle;
        end
        total++; if (m_cnt !== 0 || grant !== 4'b0001) begin bad++; $display("FAIL full_regrant: got %b want 0001", grant); end
        valid = '0;
        cycle;
    endtask

    task automatic test_clk_en;
        do_reset;
        valid = 4'b0010;
        cycle;
        #1; total++; if (w_en !== 1'b1) begin bad++; $display("FAIL ce_first_w_en: got %b want 1", w_en); end
        cycle;
        valid  = 4'b0011;
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (w_en !== 1'b0) begin bad++; $display("FAIL ce_w_en[%0d]: got %b want 0", i, w_en); end
            total++; if (ready !== 4'b0000) begin bad++; $display("FAIL ce_ready[%0d]: got %b want 0000", i, ready); end
            total++; if (grant !== 4'b0010) begin bad++; $display("FAIL ce_grant[%0d]: got %b want 0010", i, grant); end
            cycle;
        end
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (grant !== 4'b0010 || w_en !== 1'b1) begin bad++; $display("FAIL ce_resume[%0d]: got grant=%b w_en=%b want 0010/1", i, grant, w_en); end
            cycle;
        end
        #1; total++; if (grant !== 4'b0001) begin bad++; $display("FAIL ce_handoff: got %b want 0001", grant); end
        valid = '0;
        cycle;
    endtask

    task automatic test_async_reset;
        do_reset;
        valid = 4'b1100;
        cycle;
        #1; total++; if (grant !== 4'b0100) begin bad++; $display("FAIL ar_grant: got %b want 0100", grant); end
        cycle;
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL ar_grant_now: got %b want 0000", grant); end
        total++; if (w_en !== 1'b0) begin bad++; $display("FAIL ar_w_en_now: got %b want 0", w_en); end
        total++; if (ready !== 4'b0000) begin bad++; $display("FAIL ar_ready_now: got %b want 0000", ready); end
        model_reset;
        valid = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        cycle;
        #1; total++; if (grant !== 4'b0001) begin bad++; $display("FAIL ar_first_grant: got %b want 0001", grant); end
        valid = '0;
        cycle;
    endtask

`ifdef FIFO_ARB_LOCK_EN
    task automatic test_lock;
        do_reset;
        valid = 4'b1010;
        lock  = 4'b0010;
        cycle;
        for (int i = 0; i < 10; i++) begin
            data[W +: W] = 8'($urandom);
            #1;
            total++; if (grant !== 4'b0010 || w_en !== 1'b1) begin bad++; $display("FAIL lock_beat[%0d]: got grant=%b w_en=%b want 0010/1", i, grant, w_en); end
            cycle;
        end
        lock   = 4'b0000;
        w_full = 1'b1;
        #1; total++; if (grant !== 4'b0010) begin bad++; $display("FAIL lock_hold: got %b want 0010", grant); end
        cycle;
        #1; total++; if (grant !== 4'b1000) begin bad++; $display("FAIL lock_handoff: got %b want 1000", grant); end
        w_full = 1'b0;
        valid  = '0;
        cycle;
    endtask
`endif

    task automatic test_random;
        logic [W-1:0] q[N][$];
        int acc, left;
        do_reset;
        valid = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 30; j++) q[k].push_back(W'($urandom));
        for (int c = 0; c < 700; c++) begin
            if (c < 400) begin
                w_full = ($urandom_range(4) == 0);
                clk_en = ($urandom_range(6) != 0);
`ifdef FIFO_ARB_LOCK_EN
                lock   = N'($urandom);
`endif
            end else begin
                w_full = 1'b0; clk_en = 1'b1;
`ifdef FIFO_ARB_LOCK_EN
                lock   = '0;
`endif
            end
            for (int k = 0; k < N; k++)
                if (!valid[k] && q[k].size() > 0 && $urandom_range(2) != 0) begin
                    valid[k] = 1'b1;
                    data[k*W +: W] = q[k][0];
                end
            #1;
            calc_exp;
            total++; if (grant !== e_grant) begin bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, grant, e_grant); end
            total++; if (w_en !== e_wen) begin bad++; $display("FAIL rnd_w_en[%0d]: got %b want %b", c, w_en, e_wen); end
            total++; if (w_data !== e_wdata) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, w_data, e_wdata); end
            total++; if (ready !== e_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, ready, e_ready); end
            acc = e_wen ? m_owner : -1;
            cycle;
            if (acc >= 0) begin
                void'(q[acc].pop_front());
                valid[acc] = 1'b0;
            end
        end
        left = 0;
        for (int k = 0; k < N; k++) left += q[k].size();
        total++; if (left != 0) begin bad++; $display("FAIL rnd_drain: got %0d words left want 0", left); end
        valid = '0;
        cycle;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; w_full = 1'b0; valid = '0; data = '0;
`ifdef FIFO_ARB_LOCK_EN
        lock = '0;
`endif
        model_reset;
        @(negedge clk);
        test_reset;
        test_single;
        test_round_robin;
        test_full_stall;
        test_clk_en;
        test_async_reset;
`ifdef FIFO_ARB_LOCK_EN
        test_lock;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
